injetor_erros_seq: RTL and testbench

//  Pipelined, parametrised bit-error injector for the codeword path, placed between encoder and decoder.
//  - Data moves under a valid/ready handshake.
//  - XORs a programmable error mask into each accepted word: off, single bit, double bit or burst.
//  - Injection rate is set by a period counter.
//  - Counts injected errors so the bench can check decoder detect/correct statistics.

---
 rtl/injetor_erros_seq_if.sv | 20 ++
 rtl/injetor_erros_seq.sv | 124 ++++++++++++
 tb/tb_injetor_erros_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/injetor_erros_seq_if.sv
// Codeword stream into and out of the error injector.
// The master drives the upstream word and the downstream ready; the slave is the injector.
interface injetor_erros_seq_if #(parameter int W = 15);
   logic         entrada_valida;
   logic [W-1:0] entrada;
   logic         entrada_pronta;
   logic         saida_valida;
   logic [W-1:0] saida;
   logic         saida_pronta;

   modport master (
      output entrada_valida, entrada, saida_pronta,
      input  entrada_pronta, saida_valida, saida
   );

   modport slave (
      input  entrada_valida, entrada, saida_pronta,
      output entrada_pronta, saida_valida, saida
   );
endinterface

// File: rtl/injetor_erros_seq.sv
// Pipelined bit-error injector (one output register) with period-gated off/single/double/burst masks.
// Define INJETOR_LFSR_EN to draw the single-bit position from a 16-bit LFSR instead of n.

// Decides whether codeword bit POS is flipped for the sampled mode and positions.
module injetor_erros_bit #(
   parameter int IDXW = 4,
   parameter int POS  = 0
) (
   input  logic [1:0]    modo,
   input  logic [IDXW:0] p1,
   input  logic [IDXW:0] p2,
   input  logic [IDXW:0] ini,
   input  logic [IDXW:0] fim,
   output logic          flip
);
   localparam logic [IDXW:0] PV = (IDXW+1)'(POS);

   always_comb begin
      flip = 1'b0;
      case (modo)
         2'd1:    flip = (PV == p1);
         2'd2:    flip = (PV == p1) || (PV == p2);
         2'd3:    flip = (PV >= ini) && (PV < fim);
         default: flip = 1'b0;
      endcase
   end
endmodule

module injetor_erros_seq #(
   parameter int W    = 15,
   parameter int IDXW = 4,
   parameter int PW   = 8,
   parameter int CW   = 16
) (
   input  logic               clk,
   input  logic               rst,
   injetor_erros_seq_if.slave bus,
   input  logic               erro,
   input  logic [1:0]         modo,
   input  logic [IDXW-1:0]    n,
   input  logic [IDXW-1:0]    n2,
   input  logic [IDXW-1:0]    rajada_len,
   input  logic [PW-1:0]      periodo,
   output logic               erro_injetado,
   output logic [CW-1:0]      contagem_erros
);
   logic            saida_valida_r;
   logic [W-1:0]    saida_r;
   logic [PW-1:0]   pc;
   logic [PW-1:0]   per_m1;
   logic            slot;
   logic            aceita;
   logic [IDXW:0]   p1, p2, ini, fim;
   logic [IDXW-1:0] len;
   logic [W-1:0]    flips;
   logic [W-1:0]    mask;

   assign bus.entrada_pronta = !saida_valida_r || bus.saida_pronta;
   assign bus.saida_valida   = saida_valida_r;
   assign bus.saida          = saida_r;
   assign aceita             = bus.entrada_valida && bus.entrada_pronta;

   // A slot fires once pc reaches periodo-1; ">=" makes a shrunken period take effect at once.
   assign per_m1 = (periodo == '0) ? '0 : periodo - 1'b1;
   assign slot   = (pc >= per_m1);

   assign len = (rajada_len == '0) ? IDXW'(1) : rajada_len;
   assign ini = {1'b0, n};
   assign fim = ini + {1'b0, len};
   assign p2  = {1'b0, n2};

`ifdef INJETOR_LFSR_EN
   localparam logic [IDXW:0] WX = (IDXW+1)'(W);
   logic [15:0]   lfsr;
   logic [IDXW:0] pe;

   assign pe = {1'b0, lfsr[IDXW-1:0]};
   assign p1 = (pe >= WX) ? pe - WX : pe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= 16'hACE1;
      else if (aceita)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`else
   assign p1 = {1'b0, n};
`endif

   // Only lanes 0..W-1 exist, so positions >= W and burst overrun drop out naturally.
   for (genvar i = 0; i < W; i++) begin : g_bit
      injetor_erros_bit #(.IDXW(IDXW), .POS(i)) u_bit (
         .modo (modo),
         .p1   (p1),
         .p2   (p2),
         .ini  (ini),
         .fim  (fim),
         .flip (flips[i])
      );
   end

   assign mask = (erro && slot) ? flips : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         saida_valida_r <= 1'b0;
         saida_r        <= '0;
         erro_injetado  <= 1'b0;
         contagem_erros <= '0;
         pc             <= '0;
      end else if (aceita) begin
         saida_valida_r <= 1'b1;
         saida_r        <= bus.entrada ^ mask;
         erro_injetado  <= (mask != '0);
         if (erro)
            pc <= slot ? '0 : pc + 1'b1;
         if ((mask != '0) && (contagem_erros != '1))
            contagem_erros <= contagem_erros + 1'b1;
      end else if (bus.saida_pronta) begin
         saida_valida_r <= 1'b0;
         erro_injetado  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_injetor_erros_seq.sv
// Directed bench for injetor_erros_seq: a behavioural model checked every cycle plus literal expectations.
module tb_injetor_erros_seq;
   localparam int W = 15, IDXW = 4, PW = 8, CW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            erro = 1'b0;
   logic [1:0]      modo = 2'd0;
   logic [IDXW-1:0] n = '0, n2 = '0, rajada_len = '0;
   logic [PW-1:0]   periodo = '0;
   logic            erro_injetado;
   logic [CW-1:0]   contagem_erros;

   injetor_erros_seq_if #(.W(W)) bus ();

   injetor_erros_seq #(.W(W), .IDXW(IDXW), .PW(PW), .CW(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus.slave),
      .erro           (erro),
      .modo           (modo),
      .n              (n),
      .n2             (n2),
      .rajada_len     (rajada_len),
      .periodo        (periodo),
      .erro_injetado  (erro_injetado),
      .contagem_erros (contagem_erros)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mask built straight from the position rules, state kept as plain integers.
   bit        mv, mi;
   int        md, mc, mpc;
   bit [15:0] ml;

   function automatic int bitmask(input int p);
      return (p < W) ? (1 << p) : 0;
   endfunction

   function automatic int model_mask(input int m, input int a, input int b, input int l, input bit [15:0] lf);
      int r = 0;
      int pa = a;
      int bl = (l == 0) ? 1 : l;
`ifdef INJETOR_LFSR_EN
      pa = lf % 16;
      if (pa >= W) pa = pa - W;
`endif
      case (m)
         1: r = bitmask(pa);
         2: r = bitmask(a) | bitmask(b);
         3: for (int k = 0; k < bl; k++) r |= bitmask(a + k);
         default: r = 0;
      endcase
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mv = 0; mi = 0; md = 0; mc = 0; mpc = 0; ml = 16'hACE1;
      end else if (bus.entrada_valida && (!mv || bus.saida_pronta)) begin
         int pm, mk;
         bit sl;
         pm = (periodo == 0) ? 1 : int'(periodo);
         sl = (mpc >= pm - 1);
         mk = (erro && sl) ? model_mask(int'(modo), int'(n), int'(n2), int'(rajada_len), ml) : 0;
         if (erro) mpc = sl ? 0 : mpc + 1;
         md = int'(bus.entrada) ^ mk;
         mi = (mk != 0);
         mv = 1;
         if (mk != 0 && mc != 32'hFFFF) mc = mc + 1;
         ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
      end else if (bus.saida_pronta) begin
         mv = 0;
      end
   end

   always @(negedge clk) begin
      chk("pronta", 32'(bus.entrada_pronta), 32'(!mv || bus.saida_pronta));
      chk("valida", 32'(bus.saida_valida), 32'(mv));
      chk("contagem", 32'(contagem_erros), mc);
      if (mv) begin
         chk("saida", 32'(bus.saida), md);
         chk("injetado", 32'(erro_injetado), 32'(mi));
      end
   end

   task automatic ctl(input bit e, input int m, input int a, input int b, input int l, input int p);
      erro = e; modo = 2'(m); n = IDXW'(a); n2 = IDXW'(b); rajada_len = IDXW'(l); periodo = PW'(p);
   endtask

   // Presents one word and returns 1 ns after the edge that accepted it.
   task automatic send(input int d);
      bit acc;
      bus.entrada_valida = 1'b1;
      bus.entrada = W'(d);
      for (int t = 0; t < 20; t++) begin
         #1 acc = bus.entrada_pronta;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int c);
      bus.entrada_valida = 1'b0;
      repeat (c) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.entrada_valida = 1'b0;
      bus.entrada = '0;
      bus.saida_pronta = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valida", 32'(bus.saida_valida), 32'd0);
      chk("rst_saida", 32'(bus.saida), 32'd0);
      chk("rst_contagem", 32'(contagem_erros), 32'd0);
      chk("rst_injetado", 32'(erro_injetado), 32'd0);
      rst = 1'b0;

      ctl(1, 1, 3, 0, 0, 1); send(0);
`ifdef INJETOR_LFSR_EN
      chk("lfsr_first", 32'(bus.saida), 32'h0002);
`else
      chk("single_n3", 32'(bus.saida), 32'h0008);
`endif
      chk("single_inj", 32'(erro_injetado), 32'd1);
      chk("single_cnt", 32'(contagem_erros), 32'd1);

      ctl(1, 2, 0, 14, 0, 1); send(32'h1234);
      chk("double_0_14", 32'(bus.saida), 32'h5235);
      ctl(1, 2, 5, 5, 0, 1); send(0);
      chk("double_same", 32'(bus.saida), 32'h0020);
      ctl(1, 3, 12, 0, 5, 1); send(0);
      chk("burst_trunc", 32'(bus.saida), 32'h7000);
      ctl(1, 3, 12, 0, 0, 1); send(0);
      chk("burst_len0", 32'(bus.saida), 32'h1000);
      chk("burst_cnt", 32'(contagem_erros), 32'd5);

      ctl(1, 1, 15, 0, 0, 1); send(32'h0AAA);
`ifndef INJETOR_LFSR_EN
      chk("n_out_range", 32'(bus.saida), 32'h0AAA);
      chk("n_out_inj", 32'(erro_injetado), 32'd0);
      chk("n_out_cnt", 32'(contagem_erros), 32'd5);
`endif

      ctl(1, 1, 0, 0, 0, 4);
      for (int i = 1; i <= 12; i++) begin
         send(2 * i);
`ifndef INJETOR_LFSR_EN
         if (i == 4) chk("per4_word4", 32'(bus.saida), 32'h0009);
         if (i == 5) chk("per4_word5", 32'(bus.saida), 32'h000A);
`endif
      end
`ifndef INJETOR_LFSR_EN
      chk("per4_cnt", 32'(contagem_erros), 32'd8);
`endif

      // Backpressure: word held in the output register while downstream stalls.
      idle(1);
      bus.saida_pronta = 1'b0;
      ctl(1, 2, 2, 2, 0, 1); send(0);
      chk("bp_first", 32'(bus.saida), 32'h0004);
      bus.entrada_valida = 1'b1;
      bus.entrada = W'(32'h7FFF);
      ctl(1, 2, 1, 1, 0, 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("bp_pronta", 32'(bus.entrada_pronta), 32'd0);
         chk("bp_hold", 32'(bus.saida), 32'h0004);
      end
      bus.saida_pronta = 1'b1;
      send(32'h7FFF);
      chk("bp_release", 32'(bus.saida), 32'h7FFD);

      // Mid-stream async reset must also clear the period counter.
      ctl(1, 2, 0, 0, 0, 3); send(0);
      #1 rst = 1'b1;
      #1;
      chk("arst_valida", 32'(bus.saida_valida), 32'd0);
      chk("arst_cnt", 32'(contagem_erros), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      ctl(1, 2, 0, 0, 0, 2); send(0);
      chk("arst_pc0", 32'(bus.saida), 32'h0000);
      send(0);
      chk("arst_slot", 32'(bus.saida), 32'h0001);

      // Period shrink while pc is already past the new limit.
      ctl(1, 2, 1, 1, 0, 4);
      for (int i = 0; i < 3; i++) send(0);
      chk("per_chg_pre", 32'(contagem_erros), 32'd1);
      ctl(1, 2, 1, 1, 0, 2); send(0);
      chk("per_chg_slot", 32'(bus.saida), 32'h0002);
      ctl(0, 2, 1, 1, 0, 2); send(0);
      chk("erro0_none", 32'(bus.saida), 32'h0000);
      ctl(1, 2, 1, 1, 0, 2); send(0);
      chk("erro0_hold_pc", 32'(bus.saida), 32'h0000);
      send(0);
      chk("erro0_slot", 32'(bus.saida), 32'h0002);
      chk("final_cnt", 32'(contagem_erros), 32'd3);

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
